// File: rtl/a78_pkg.sv
// Shared constants and types for the A78 cartridge loader.
package a78_pkg;

  localparam int unsigned SIG_OFS    = 1;
  localparam int unsigned SIZE_OFS   = 49;
  localparam int unsigned FLAGS_OFS  = 53;
  localparam int unsigned REGION_OFS = 57;
  localparam int unsigned SAVE_OFS   = 58;
  localparam int unsigned XM_OFS     = 63;
  localparam int unsigned HDR_LEN    = 128;

  localparam logic [39:0] SIG_ATARI = 40'h41_54_41_52_49;

  typedef enum logic [2:0] {IDLE, SIG, HDR, FLUSH, BODY, END} state_t;

  typedef enum logic [7:0] {
    NONE    = 8'd0,
    HSC     = 8'd1,
    SAVEKEY = 8'd2
  } save_t;

endpackage

// File: rtl/a78_header_regs.sv
// A78 header field registers: maps header byte offsets onto the latched fields.
module a78_header_regs
  import a78_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        i_we,
  input  logic [6:0]  i_ofs,
  input  logic [7:0]  i_data,
  output logic [31:0] o_hcart_size,
  output logic [15:0] o_cart_flags,
  output logic [7:0]  o_cart_region,
  output logic [7:0]  o_cart_save,
  output logic [7:0]  o_cart_xm
);

  logic [31:0] r_hcart_size;
  logic [15:0] r_cart_flags;
  logic [7:0]  r_cart_region;
  logic [7:0]  r_cart_save;
  logic [7:0]  r_cart_xm;

  // Multi-byte fields are big-endian: the lowest offset holds the MSB.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hcart_size  <= 32'h0000_8000;
      r_cart_flags  <= '0;
      r_cart_region <= '0;
      r_cart_save   <= '0;
      r_cart_xm     <= '0;
    end else if (i_we) begin
      case (i_ofs)
        7'(SIZE_OFS):      r_hcart_size[31:24] <= i_data;
        7'(SIZE_OFS + 1):  r_hcart_size[23:16] <= i_data;
        7'(SIZE_OFS + 2):  r_hcart_size[15:8]  <= i_data;
        7'(SIZE_OFS + 3):  r_hcart_size[7:0]   <= i_data;
        7'(FLAGS_OFS):     r_cart_flags[15:8]  <= i_data;
        7'(FLAGS_OFS + 1): r_cart_flags[7:0]   <= i_data;
        7'(REGION_OFS):    r_cart_region       <= i_data;
        7'(SAVE_OFS):      r_cart_save         <= i_data;
        7'(XM_OFS):        r_cart_xm           <= i_data;
        default: ;
      endcase
    end
  end

  assign o_hcart_size  = r_hcart_size;
  assign o_cart_flags  = r_cart_flags;
  assign o_cart_region = r_cart_region;
  assign o_cart_save   = r_cart_save;
  assign o_cart_xm     = r_cart_xm;

endmodule

// File: rtl/a78_cart_loader.sv
// Cart download front-end: detects/strips A78 headers and streams payload to cart RAM.
// Define A78_CHECKSUM_EN to add the payload_sum output.
module a78_cart_loader #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned HDR_LEN = 128,
  parameter int unsigned SIG_LEN = 6
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              is_7800,
  output logic [31:0]       hcart_size,
  output logic [15:0]       cart_flags,
  output logic [7:0]        cart_region,
  output logic [7:0]        cart_save,
  output logic [7:0]        cart_xm,
  output logic [31:0]       cart_size,
  output logic              load_done
`ifdef A78_CHECKSUM_EN
  ,
  output logic [15:0]       payload_sum
`endif
);
  import a78_pkg::*;

  localparam int unsigned CW = $clog2(SIG_LEN + 1);

  state_t            r_state, w_next;
  logic              r_dl_d, r_any, r_end_pend, r_is_7800, r_ram_we, r_load_done;
  logic [7:0]        r_buf [SIG_LEN];
  logic [CW-1:0]     r_fl_idx, r_fl_cnt, w_fl_n;
  logic [24:0]       r_last_addr, w_last;
  logic [ADDR_W-1:0] r_ram_addr, w_waddr;
  logic [7:0]        r_ram_data, w_wdata, w_fl_byte;
  logic [31:0]       r_cart_size, w_len, w_size;
  logic              w_rise, w_fall, w_wr, w_acc, w_any, w_match, w_we, w_hdr_we;

  assign ioctl_wait = (r_state == FLUSH);
  assign w_rise     = dl_active & ~r_dl_d;
  assign w_fall     = ~dl_active & r_dl_d;
  assign w_wr       = ioctl_wr & ~ioctl_wait;
  assign w_acc      = w_wr & (r_state inside {SIG, HDR, BODY});
  assign w_any      = r_any | w_acc;
  assign w_last     = w_acc ? ioctl_addr : r_last_addr;
  assign w_match    = ({r_buf[SIG_OFS], r_buf[SIG_OFS+1], r_buf[SIG_OFS+2],
                        r_buf[SIG_OFS+3], ioctl_dout} == SIG_ATARI);
  assign w_fl_n     = (w_last < 25'(SIG_LEN)) ? CW'(w_last) + 1'b1 : CW'(SIG_LEN);
  assign w_hdr_we   = (r_state == HDR) & w_wr & (ioctl_addr < 25'(HDR_LEN));

  assign w_len  = 32'(r_last_addr) + 32'd1;
  assign w_size = !r_any     ? '0 :
                  !r_is_7800 ? w_len :
                  (w_len > 32'(HDR_LEN)) ? w_len - 32'(HDR_LEN) : '0;

  always_comb begin
    w_fl_byte = '0;
    for (int unsigned i = 0; i < SIG_LEN; i++)
      if (r_fl_idx == CW'(i)) w_fl_byte = r_buf[i];
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_rise) w_next = SIG;
      SIG:   if (w_fall) w_next = w_any ? FLUSH : END;
             else if (w_wr && ioctl_addr == 25'(SIG_LEN - 1)) w_next = w_match ? HDR : FLUSH;
      HDR:   if (w_fall) w_next = END;
             else if (w_wr && ioctl_addr == 25'(HDR_LEN - 1)) w_next = BODY;
      FLUSH: if (r_fl_idx == r_fl_cnt - 1'b1) w_next = (r_end_pend || w_fall) ? END : BODY;
      BODY:  if (w_fall) w_next = END;
      END:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = ioctl_dout;
    if (r_state == FLUSH) begin
      w_we    = 1'b1;
      w_waddr = ADDR_W'(r_fl_idx);
      w_wdata = w_fl_byte;
    end else if (r_state == BODY && w_wr) begin
      if (!r_is_7800) begin
        w_we    = 1'b1;
        w_waddr = ioctl_addr[ADDR_W-1:0];
      end else if (ioctl_addr >= 25'(HDR_LEN)) begin
        w_we    = 1'b1;
        w_waddr = ioctl_addr[ADDR_W-1:0] - ADDR_W'(HDR_LEN);
      end
    end
  end

  // r_dl_d resets high so a download already in progress at reset release is not restarted mid-file.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_dl_d      <= 1'b1;
      r_any       <= 1'b0;
      r_end_pend  <= 1'b0;
      r_is_7800   <= 1'b1;
      r_fl_idx    <= '0;
      r_fl_cnt    <= '0;
      r_last_addr <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_cart_size <= '0;
      r_load_done <= 1'b0;
      for (int unsigned i = 0; i < SIG_LEN; i++) r_buf[i] <= '0;
    end else begin
      r_state     <= w_next;
      r_dl_d      <= dl_active;
      r_ram_we    <= w_we;
      r_load_done <= (r_state == END);
      if (w_we) begin
        r_ram_addr <= w_waddr;
        r_ram_data <= w_wdata;
      end
      if (r_state == IDLE && w_rise) begin
        r_any       <= 1'b0;
        r_end_pend  <= 1'b0;
        r_last_addr <= '0;
        for (int unsigned i = 0; i < SIG_LEN; i++) r_buf[i] <= '0;
      end
      if (w_acc) begin
        r_any       <= 1'b1;
        r_last_addr <= ioctl_addr;
      end
      if (r_state == SIG && w_acc)
        for (int unsigned i = 0; i < SIG_LEN; i++)
          if (ioctl_addr == 25'(i)) r_buf[i] <= ioctl_dout;
      if (r_state == SIG && w_next == HDR) r_is_7800 <= 1'b1;
      if (r_state == SIG && (w_next == FLUSH || w_next == END)) r_is_7800 <= 1'b0;
      if (r_state == SIG && w_next == FLUSH) begin
        r_fl_idx   <= '0;
        r_fl_cnt   <= w_fl_n;
        r_end_pend <= w_fall;
      end
      if (r_state == FLUSH) begin
        r_fl_idx <= r_fl_idx + 1'b1;
        if (w_fall) r_end_pend <= 1'b1;
      end
      if (r_state == END) r_cart_size <= w_size;
    end
  end

  a78_header_regs u_hdr (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .i_we          (w_hdr_we),
    .i_ofs         (ioctl_addr[6:0]),
    .i_data        (ioctl_dout),
    .o_hcart_size  (hcart_size),
    .o_cart_flags  (cart_flags),
    .o_cart_region (cart_region),
    .o_cart_save   (cart_save),
    .o_cart_xm     (cart_xm)
  );

`ifdef A78_CHECKSUM_EN
  logic [15:0] r_sum;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                    r_sum <= '0;
    else if (r_state == IDLE && w_rise) r_sum <= '0;
    else if (w_we)                   r_sum <= r_sum + 16'(w_wdata);
  end

  assign payload_sum = r_sum;
`endif

  assign is_7800   = r_is_7800;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_data  = r_ram_data;
  assign cart_size = r_cart_size;
  assign load_done = r_load_done;

endmodule

// File: tb/tb_a78_cart_loader.sv
// Self-checking bench for a78_cart_loader: random images against a file-level reference model.
`timescale 1ns/1ps
module tb_a78_cart_loader;
  import a78_pkg::*;

  localparam int unsigned AW = 12;

  logic          clk_sys = 1'b0;
  logic          reset_n, dl_active, ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait, ram_we, is_7800, load_done;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data, cart_region, cart_save, cart_xm;
  logic [31:0]   hcart_size, cart_size;
  logic [15:0]   cart_flags;
`ifdef A78_CHECKSUM_EN
  logic [15:0]   payload_sum;
`endif

  int unsigned checks = 0, errors = 0;

  always #5 clk_sys = ~clk_sys;

  a78_cart_loader #(.ADDR_W(AW), .HDR_LEN(128), .SIG_LEN(6)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .is_7800(is_7800),
    .hcart_size(hcart_size), .cart_flags(cart_flags), .cart_region(cart_region),
    .cart_save(cart_save), .cart_xm(cart_xm), .cart_size(cart_size), .load_done(load_done)
`ifdef A78_CHECKSUM_EN
    , .payload_sum(payload_sum)
`endif
  );

  // Monitor: RAM write log, wait-cycle count and load_done snapshots.
  logic [AW-1:0] got_a[$];
  logic [7:0]    got_d[$];
  int unsigned   wait_cyc = 0, done_cnt = 0;
  logic [31:0]   done_size = '0;

  always @(negedge clk_sys) begin
    if (ram_we) begin
      got_a.push_back(ram_addr);
      got_d.push_back(ram_data);
    end
    if (ioctl_wait) wait_cyc <= wait_cyc + 1;
    if (load_done) begin
      done_cnt  <= done_cnt + 1;
      done_size <= cart_size;
    end
  end

  // Reference state: header fields persist across downloads until overwritten.
  logic [7:0]  file[$];
  logic        m_is7800 = 1'b1;
  logic [31:0] m_hsize  = 32'h8000;
  logic [15:0] m_flags  = '0;
  logic [7:0]  m_region = '0, m_save = '0, m_xm = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ram_we"}, ram_we, 0);
    chk({p, "_ram_addr"}, ram_addr, 0);
    chk({p, "_ram_data"}, ram_data, 0);
    chk({p, "_wait"}, ioctl_wait, 0);
    chk({p, "_is_7800"}, is_7800, 1);
    chk({p, "_hcart_size"}, hcart_size, 32'h8000);
    chk({p, "_flags"}, cart_flags, 0);
    chk({p, "_region"}, cart_region, 0);
    chk({p, "_save"}, cart_save, 0);
    chk({p, "_xm"}, cart_xm, 0);
    chk({p, "_cart_size"}, cart_size, 0);
    chk({p, "_load_done"}, load_done, 0);
`ifdef A78_CHECKSUM_EN
    chk({p, "_sum"}, payload_sum, 0);
`endif
  endtask

  task automatic build_7800(input int unsigned len, input bit ff_body);
    string sg = "ATARI7800";
    file.delete();
    for (int unsigned i = 0; i < len; i++) file.push_back(ff_body && i >= 128 ? 8'hFF : 8'($urandom));
    for (int unsigned k = 0; k < 9; k++) if (k + 1 < len) file[k+1] = sg[k];
  endtask

  task automatic build_2600(input int unsigned len);
    file.delete();
    for (int unsigned i = 0; i < len; i++) file.push_back(8'($urandom));
    if (len > 1) file[1] = 8'h41 ^ 8'($urandom_range(255, 1));
  endtask

  task automatic run_file(input string tag, input int unsigned maxgap, input bit inject, input int abort_at);
    int unsigned   bw, bwait, bdone, guard, len, nbad, ewait;
    logic [AW-1:0] ea[$];
    logic [7:0]    ed[$];
    logic [31:0]   esize;
    logic [15:0]   esum;
    bit            sig;
    bw = got_a.size(); bwait = wait_cyc; bdone = done_cnt; len = file.size();
    dl_active = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    for (int i = 0; i < int'(len); i++) begin
      guard = 0;
      while (ioctl_wait && guard < 20) begin
        ioctl_wr = inject; ioctl_addr = 25'h1FF_FFFF; ioctl_dout = 8'($urandom);
        @(posedge clk_sys); #1; guard++;
      end
      if (ioctl_wait) chk({tag, "_wait_stuck"}, ioctl_wait, 0);
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = file[i];
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
      if (i == abort_at) begin
        chk({tag, "_we_before_reset"}, ram_we, 1);
        reset_n = 1'b0;
        #1;
        chk_reset({tag, "_async"});
        dl_active = 1'b0;
        m_is7800 = 1'b1; m_hsize = 32'h8000; m_flags = '0; m_region = '0; m_save = '0; m_xm = '0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        return;
      end
      repeat ($urandom_range(maxgap, 0)) begin @(posedge clk_sys); #1; end
    end
    dl_active = 1'b0;
    guard = 0;
    while (done_cnt == bdone && guard < 100) begin @(posedge clk_sys); #1; guard++; end
    repeat (3) @(posedge clk_sys);
    #1;

    sig = (len >= 6) && file[1] == 8'h41 && file[2] == 8'h54 && file[3] == 8'h41 &&
          file[4] == 8'h52 && file[5] == 8'h49;
    esum = '0;
    for (int unsigned i = 0; i < len; i++) begin
      if (!sig || i >= 128) begin
        ea.push_back(AW'(sig ? i - 128 : i));
        ed.push_back(file[i]);
        esum += 16'(file[i]);
      end
    end
    esize = sig ? (len > 128 ? len - 128 : 0) : len;
    ewait = sig ? 0 : (len < 6 ? len : 6);
    if (sig)
      for (int unsigned o = 49; o < 64 && o < len; o++)
        case (o)
          49: m_hsize[31:24] = file[o];
          50: m_hsize[23:16] = file[o];
          51: m_hsize[15:8]  = file[o];
          52: m_hsize[7:0]   = file[o];
          53: m_flags[15:8]  = file[o];
          54: m_flags[7:0]   = file[o];
          57: m_region       = file[o];
          58: m_save         = file[o];
          63: m_xm           = file[o];
          default: ;
        endcase
    m_is7800 = sig;

    chk({tag, "_load_done_pulses"}, done_cnt - bdone, 1);
    chk({tag, "_cart_size_at_done"}, done_size, esize);
    chk({tag, "_cart_size_hold"}, cart_size, esize);
    chk({tag, "_is_7800"}, is_7800, m_is7800);
    chk({tag, "_hcart_size"}, hcart_size, m_hsize);
    chk({tag, "_flags"}, cart_flags, m_flags);
    chk({tag, "_region"}, cart_region, m_region);
    chk({tag, "_save"}, cart_save, m_save);
    chk({tag, "_xm"}, cart_xm, m_xm);
    chk({tag, "_wait_cycles"}, wait_cyc - bwait, ewait);
    chk({tag, "_wr_count"}, got_a.size() - bw, ea.size());
    nbad = 0;
    for (int k = 0; k < ea.size(); k++)
      if (bw + k >= got_a.size() || got_a[bw+k] !== ea[k] || got_d[bw+k] !== ed[k]) nbad++;
    chk({tag, "_wr_stream_bad"}, nbad, 0);
`ifdef A78_CHECKSUM_EN
    chk({tag, "_payload_sum"}, payload_sum, esum);
`endif
  endtask

  initial begin
    int unsigned bw0;
    reset_n = 1'b0; dl_active = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk_reset("por");
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    // 7800 image with 32 KiB body; RAM index wraps at 2^AW.
    build_7800(128 + 32768, 1'b0);
    file[49] = 8'h00; file[50] = 8'h00; file[51] = 8'h80; file[52] = 8'h00;
    file[57] = 8'h01; file[58] = HSC; file[63] = 8'($urandom_range(255, 1));
    bw0 = got_a.size();
    run_file("a78_32k", 0, 1'b0, -1);
    chk("a78_first_we_addr", got_a[bw0], 0);
    chk("a78_first_we_data", got_d[bw0], file[128]);
    chk("a78_region_is_1", cart_region, 8'h01);
    chk("a78_size_32k", cart_size, 32768);

    // Headerless 2600 image; junk strobes presented while stalled.
    build_2600(4096);
    file[1] = 8'hA9;
    run_file("vcs_4k", 1, 1'b1, -1);

    build_2600(3);
    run_file("tiny_3", 1, 1'b0, -1);

    // Header cut at 60 bytes: XM byte (63) never arrives.
    build_7800(60, 1'b0);
    run_file("trunc_60", 1, 1'b0, -1);

    for (int n = 0; n < 4; n++) begin
      if ($urandom_range(1, 0) == 1) build_7800($urandom_range(300, 100), 1'b0);
      else build_2600($urandom_range(40, 1));
      run_file($sformatf("rand%0d", n), 2, 1'($urandom_range(1, 0)), -1);
    end

    build_7800(128 + 256, 1'b1);
    run_file("ff_body", 0, 1'b0, -1);
`ifdef A78_CHECKSUM_EN
    chk("ff_body_sum_ff00", payload_sum, 16'hFF00);
`endif

    build_7800(128 + 2000, 1'b0);
    run_file("rst_body1000", 0, 1'b0, 128 + 1000);

    build_2600(20);
    run_file("after_rst", 1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/a78_cart_loader.md
Name: a78_cart_loader

Overview:
- Upstream stage between the HPS ioctl download stream and the cart SPRAM / Atari7800 core.
- Detects an A78 header from the "ATARI" signature at offsets 1-5. For 7800 images it strips the 128-byte header and latches the header fields; headerless 2600 images pass through unchanged.
- Produces registered cart-RAM write strobes, the header fields, and the final cart size when the download ends.
- A 6-byte signature buffer plus a flush state lets the first bytes of a headerless image reach RAM after the format decision is made.

Parameters:
- ADDR_W, 18, cart RAM address width.
- HDR_LEN, 128, A78 header length in bytes.
- SIG_LEN, 6, bytes buffered before the format decision (offsets 0-5).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- dl_active  in  1  cart download active (ioctl_download & index==1).
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte offset within the file.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to HPS; asserted only during FLUSH.
- ram_we  out  1  cart RAM write strobe.
- ram_addr  out  ADDR_W  cart RAM write address.
- ram_data  out  8  cart RAM write data.
- is_7800  out  1  header signature matched.
- hcart_size  out  32  header size, bytes 49-52, big-endian.
- cart_flags  out  16  header bytes 53-54.
- cart_region  out  8  header byte 57.
- cart_save  out  8  header byte 58.
- cart_xm  out  8  header byte 63.
- cart_size  out  32  payload byte count.
- load_done  out  1  one-cycle pulse when cart_size is valid.

Behaviour:
- Reset values:
  - all strobes 0, ram_addr 0, ram_data 0.
  - is_7800=1, hcart_size=32'h8000.
  - cart_flags, region, save, xm = 0.
  - cart_size = 0. State IDLE.
- Rising edge of dl_active -> SIG.
  - Clear the signature match flag and the buffer.
  - Header fields hold their previous values until overwritten.
- SIG: each ioctl_wr with addr<6 stores the byte in buf[addr] and compares offsets 1-5 against "ATARI". On the write of addr 5:
  - Match: is_7800<=1, go to HDR.
  - Mismatch: is_7800<=0, go to FLUSH.
- HDR:
  - Writes at addr 6..127 capture the header fields at the listed offsets.
  - No RAM writes.
  - Write at addr 127 -> BODY.
- FLUSH:
  - ioctl_wait=1.
  - Emit buf[0..5] on ram_we/addr/data, one per cycle, at addresses 0..5 (6 cycles).
  - Then deassert ioctl_wait and go to BODY.
- BODY: each ioctl_wr produces ram_we exactly 1 cycle later (registered).
  - ram_addr = addr-HDR_LEN if is_7800, else addr, truncated to ADDR_W.
  - 7800 writes with addr<128 are dropped.
- Every accepted ioctl_wr records last_addr.
- dl_active falling edge in any state -> END.
  - In SIG (file <6 bytes): is_7800<=0, pass through FLUSH for the bytes received (count = last_addr+1), then END.
  - In HDR (truncated header): cart_size=0.
- END:
  - cart_size <= last_addr+1-(is_7800?128:0), saturating at 0.
  - load_done pulses for 1 cycle, then IDLE.
- ioctl_wr while ioctl_wait=1 is a protocol violation: ignored, no state change.
- Addresses beyond 2^ADDR_W wrap silently; there is no overflow flag.
- Async reset mid-download: immediate return to IDLE with reset values; ram_we is never left high.

Optional Feature:
- Macro: A78_CHECKSUM_EN.
- Defined: adds output payload_sum[15:0], the modulo-2^16 sum of every byte written to RAM (including flushed bytes). Cleared on download start, final in the load_done cycle.
- Undefined: port absent, no adder logic.

Decomposition:
- Package a78_pkg:
  - offset constants: SIG_OFS=1, SIZE_OFS=49, FLAGS_OFS=53, REGION_OFS=57, SAVE_OFS=58, XM_OFS=63, HDR_LEN=128.
  - SIG_ATARI 40-bit constant.
  - state enum (IDLE, SIG, HDR, FLUSH, BODY, END).
  - save-type enum (NONE=0, HSC=1, SAVEKEY=2).
- One sub-module, a78_header_regs: decodes addr/data into the header field registers, keeping the field map out of the FSM.

Test Plan:
- 7800 image: 128-byte header "ATARI7800", size bytes 00 00 80 00, region=01, save=01, then 32 KiB body.
  - is_7800=1, hcart_size=32'h8000, cart_region=1, cart_save=1.
  - First ram_we at addr 0 carries body byte 128; cart_size=32768; one load_done pulse.
- 2600 image of 4096 bytes, byte1=0xA9:
  - After addr 5, ioctl_wait is high for exactly 6 cycles; RAM addresses 0-5 receive the original bytes.
  - is_7800=0, cart_size=4096.
- 3-byte file: FLUSH emits 3 writes; cart_size=3, is_7800=0.
- Async reset_n low at body byte 1000: ram_we=0 in the same cycle; outputs return to reset values.
- Header truncated at 60 bytes: cart_size=0, fields up to offset 58 latched, cart_xm unchanged.
- With A78_CHECKSUM_EN: body of 256 bytes each 0xFF -> payload_sum=16'hFF00.
